// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_if
// Purpose  : Fetch, data and memory-side signals of the unified memory arbiter.
// Revision : 1.0
// ============================================================================
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              dm_read;
   logic              dm_write;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              mem_error;

   modport slave (
      input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, dm_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_error
   );

   modport master (
      output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, dm_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_error
   );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-ported memory between fetch and data access,
//            data first; optional wait timeout under MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module unified_mem_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   unified_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DATA_WAIT  = 2'd1,
      FETCH_WAIT = 2'd2
   } state_t;

   state_t            r_state, w_state_next;
   logic              r_mem_req, w_mem_req_next;
   logic              r_mem_we, w_mem_we_next;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
   logic [31:0]       r_if_rdata, w_if_rdata_next;
   logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_next;
   logic              r_if_done, w_if_done_next;
   logic              r_dm_done, w_dm_done_next;
   logic              w_dm_pend;
   logic              w_stall;
   logic              w_tmo_hit;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_mem_error;

   // Abort on the edge where the wait count would reach the limit.
   assign w_tmo_hit = (r_state != IDLE) && !bus.mem_ready &&
                      (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo_cnt   <= '0;
         r_mem_error <= 1'b0;
      end else begin
         if (r_state == IDLE)
            r_tmo_cnt <= '0;
         else if (!bus.mem_ready)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         if (w_tmo_hit)
            r_mem_error <= 1'b1;
      end
   end

   assign bus.mem_error = r_mem_error;
`else
   assign w_tmo_hit     = 1'b0;
   assign bus.mem_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_done   <= 1'b0;
         r_dm_done   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_mem_req   <= w_mem_req_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
         r_if_rdata  <= w_if_rdata_next;
         r_dm_rdata  <= w_dm_rdata_next;
         r_if_done   <= w_if_done_next;
         r_dm_done   <= w_dm_done_next;
      end
   end

   always_comb begin
      w_dm_pend        = bus.dm_read | bus.dm_write;
      w_stall          = (w_dm_pend & ~r_dm_done) | (bus.if_req & ~r_if_done);
      w_state_next     = r_state;
      w_mem_req_next   = r_mem_req;
      w_mem_we_next    = r_mem_we;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_if_rdata_next  = r_if_rdata;
      w_dm_rdata_next  = r_dm_rdata;
      w_if_done_next   = r_if_done;
      w_dm_done_next   = r_dm_done;

      case (r_state)
         IDLE: begin
            if (w_dm_pend && !r_dm_done) begin
               w_state_next     = DATA_WAIT;
               w_mem_req_next   = 1'b1;
               w_mem_we_next    = bus.dm_write;
               w_mem_addr_next  = bus.dm_addr;
               w_mem_wdata_next = bus.dm_wdata;
            end else if (bus.if_req && !r_if_done) begin
               w_state_next    = FETCH_WAIT;
               w_mem_req_next  = 1'b1;
               w_mem_we_next   = 1'b0;
               w_mem_addr_next = bus.if_addr;
            end
         end
         DATA_WAIT, FETCH_WAIT: begin
            if (bus.mem_ready || w_tmo_hit) begin
               w_state_next   = IDLE;
               w_mem_req_next = 1'b0;
               // An aborted read returns zero rather than whatever is on the bus.
               if (r_state == DATA_WAIT) begin
                  w_dm_done_next = 1'b1;
                  if (!r_mem_we)
                     w_dm_rdata_next = bus.mem_ready ? bus.mem_rdata : '0;
               end else begin
                  w_if_done_next  = 1'b1;
                  w_if_rdata_next = bus.mem_ready ? bus.mem_rdata[31:0] : 32'd0;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase

      // Pipeline advances on this edge, so the step's completions are retired.
      if (!w_stall) begin
         w_if_done_next = 1'b0;
         w_dm_done_next = 1'b0;
      end
   end

   assign bus.stall     = w_stall;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;
endmodule
`default_nettype wire
